mult_issue_ctrl: RTL and testbench

//   Upstream issue/collect controller for the serial radix-4 Booth multiplier (mult).
//   - Buffers operand pairs from a valid/ready source in a small FIFO.
//   - Issues one pair at a time to mult as a 1-cycle i_valid pulse, then waits for its o_valid.
//   - Captures o_c and returns it to a valid/ready sink, one result per accepted pair, in order.

---
 rtl/mult_issue_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mult_issue_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_ctrl.sv
// rtl/mult_issue_ctrl.sv - operand FIFO, issue and result-collect controller for the serial Booth multiplier
// Optional feature macro: MULT_ISSUE_TIMEOUT_EN (adds sticky err and a WAIT timeout that emits a zero result)
module mult_issue_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_a,
  input  logic [DATA_WIDTH-1:0]   s_b,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2*DATA_WIDTH-1:0] m_c,
  output logic [DATA_WIDTH-1:0]   mult_i_a,
  output logic [DATA_WIDTH-1:0]   mult_i_b,
  output logic                    mult_i_valid,
  input  logic                    mult_o_valid,
  input  logic [2*DATA_WIDTH-1:0] mult_o_c,
`ifdef MULT_ISSUE_TIMEOUT_EN
  output logic                    err,
`endif
  output logic                    busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   fifo_a_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_b_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q;
  logic                    rst_done_q;
  logic                    m_valid_q, m_valid_d;
  logic [2*DATA_WIDTH-1:0] m_c_q, m_c_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic                    fifo_empty, fifo_full, push, pop;

`ifdef MULT_ISSUE_TIMEOUT_EN
  localparam int TO_LIMIT = DATA_WIDTH / 2 + 4;
  localparam int TW = $clog2(TO_LIMIT + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  assign err = err_q;
`endif

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  // The head leaves the FIFO on IDLE->ISSUE or on a HOLD handshake that chains straight into ISSUE.
  assign pop        = !fifo_empty && ((state_q == IDLE) || ((state_q == HOLD) && m_ready));
  assign s_ready    = rst_done_q && (!fifo_full || pop);
  assign push       = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_ptr_q] <= s_a;
      fifo_b_q[wr_ptr_q] <= s_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      rst_done_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_valid_q <= 1'b0;
      m_c_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
`ifdef MULT_ISSUE_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_c_q     <= m_c_d;
      a_q       <= a_d;
      b_q       <= b_d;
`ifdef MULT_ISSUE_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_c_d     = m_c_q;
    a_d       = a_q;
    b_d       = b_q;
`ifdef MULT_ISSUE_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    if (pop) begin
      a_d = fifo_a_q[rd_ptr_q];
      b_d = fifo_b_q[rd_ptr_q];
    end
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef MULT_ISSUE_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      // The multiplier has no reset, so its o_valid is trusted only here.
      WAIT: begin
        if (mult_o_valid) begin
          m_c_d     = mult_o_c;
          m_valid_d = 1'b1;
          state_d   = HOLD;
        end
`ifdef MULT_ISSUE_TIMEOUT_EN
        else if (cnt_q == TW'(TO_LIMIT - 1)) begin
          err_d     = 1'b1;
          m_c_d     = '0;
          m_valid_d = 1'b1;
          state_d   = HOLD;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
`endif
      end
      HOLD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = fifo_empty ? IDLE : ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_valid      = m_valid_q;
  assign m_c          = m_c_q;
  assign mult_i_a     = a_q;
  assign mult_i_b     = b_q;
  assign mult_i_valid = (state_q == ISSUE);
  assign busy         = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb/tb_mult_issue_ctrl.sv - self-checking bench for mult_issue_ctrl with a behavioural multiplier and result scoreboard
module tb_mult_issue_ctrl;

  localparam int DW = 32;
  localparam int N_RAND = 40;

  logic          clk, rst_n;
  logic          s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0] s_a, s_b, mult_i_a, mult_i_b;
  logic [2*DW-1:0] m_c, mult_o_c;
  logic          mult_i_valid, mult_o_valid, busy;

  mult_issue_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .m_valid(m_valid), .m_ready(m_ready), .m_c(m_c),
    .mult_i_a(mult_i_a), .mult_i_b(mult_i_b), .mult_i_valid(mult_i_valid),
    .mult_o_valid(mult_o_valid), .mult_o_c(mult_o_c), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int iv_count = 0;
  bit prev_iv = 1'b0;
  logic [2*DW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Behavioural multiplier: no reset, product appears DW/2+1 cycles after the edge that samples i_valid.
  logic          bm_pend = 1'b0;
  int            bm_ctr = 0;
  logic [2*DW-1:0] bm_prod = '0;
  logic          bm_ov = 1'b0;
  logic          force_ov;
  always @(posedge clk) begin
    bm_ov <= 1'b0;
    if (mult_i_valid) begin
      bm_pend <= 1'b1;
      bm_ctr  <= DW / 2 + 1;
      bm_prod <= 64'(mult_i_a) * 64'(mult_i_b);
    end else if (bm_pend) begin
      if (bm_ctr == 1) begin
        bm_pend <= 1'b0;
        bm_ov   <= 1'b1;
      end
      bm_ctr <= bm_ctr - 1;
    end
  end
  assign mult_o_valid = bm_ov | force_ov;
  assign mult_o_c     = force_ov ? 64'hDEAD_BEEF_0BAD_F00D : bm_prod;

  // Scoreboard: every accepted pair owes exactly one in-order product.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_valid && s_ready) exp_q.push_back(64'(s_a) * 64'(s_b));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("sb_extra_result", 64'd1, 64'd0);
        else chk("sb_result", m_c, exp_q.pop_front());
      end
      if (mult_i_valid) begin
        iv_count++;
        chk("iv_single_pulse", 64'(prev_iv), 64'd0);
      end
      prev_iv = mult_i_valid;
    end else begin
      prev_iv = 1'b0;
    end
  end

  task automatic wait_mvalid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("m_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic push_one(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(posedge clk); #1;
    s_valid = 1'b1; s_a = a; s_b = b;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return DW'($urandom_range(0, 15));
      default: return DW'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [2*DW-1:0] exp;
  } vec_t;
  vec_t tbl[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit acc;
    int c0, prev_c, bad, sent;
    logic [2*DW-1:0] hold_c;

    tbl[0] = '{32'd7,          32'd9,          64'd63};
    tbl[1] = '{32'd0,          32'hFFFF_FFFF,  64'd0};
    tbl[2] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF};
    tbl[3] = '{32'h0001_2345,  32'h0000_0678,  64'h0000_0000_075C_2658};
    tbl[4] = '{32'd2,          32'd2,          64'd4};

    rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0; force_ov = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_c", m_c, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_i_valid", 64'(mult_i_valid), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_at_release", 64'(s_ready), 64'd0);
    @(negedge clk);
    chk("s_ready_after_release", 64'(s_ready), 64'd1);

    // Single operation latency from the cycle s_valid is presented.
    m_ready = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    s_valid = 1'b1; s_a = 32'd3; s_b = 32'd5;
    c0 = c0;
    @(posedge clk); #1 s_valid = 1'b0;
    begin
      int iv0;
      iv0 = iv_count;
      wait_mvalid(60, ok);
      chk("single_latency", 64'(cyc - c0), 64'd21);
      chk("single_m_c", m_c, 64'd15);
      chk("single_one_issue", 64'(iv_count - iv0), 64'd1);
    end
    @(posedge clk);

    // Table: back-to-back pairs until the FIFO fills, then in-order results.
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      s_valid = 1'b1; s_a = tbl[i].a; s_b = tbl[i].b;
    end
    @(posedge clk); #1 s_valid = 1'b0;
    @(negedge clk);
    chk("full_s_ready", 64'(s_ready), 64'd0);
    chk("full_busy", 64'(busy), 64'd1);
    prev_c = 0;
    for (int i = 0; i < 5; i++) begin
      wait_mvalid(60, ok);
      chk($sformatf("tbl_result_%0d", i), m_c, tbl[i].exp);
      if (i > 0) chk($sformatf("tbl_hs_to_valid_%0d", i), 64'(cyc - (prev_c + 1)), 64'd19);
      prev_c = cyc;
      @(posedge clk);
    end

    // Backpressure: result held, no reissue, reissue the cycle after the handshake.
    @(posedge clk); #1 m_ready = 1'b0;
    push_one(32'd11, 32'd13);
    push_one(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_mvalid(60, ok);
    hold_c = m_c;
    chk("bp_first", m_c, 64'd143);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!m_valid || m_c !== hold_c || mult_i_valid) bad++;
    end
    chk("bp_hold_violations", 64'(bad), 64'd0);
    @(posedge clk); #1 m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_reissue_next_cycle", 64'(mult_i_valid), 64'd1);
    wait_mvalid(60, ok);
    chk("bp_second", m_c, 64'hFFFF_FFFE_0000_0001);
    @(posedge clk);

    // Stray o_valid in IDLE and in HOLD.
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    hold_c = m_c;
    @(posedge clk); #1 force_ov = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_valid || m_c !== hold_c) bad++;
    end
    @(posedge clk); #1 force_ov = 1'b0;
    chk("stray_idle", 64'(bad), 64'd0);
    m_ready = 1'b0;
    push_one(32'd6, 32'd7);
    wait_mvalid(60, ok);
    @(posedge clk); #1 force_ov = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (!m_valid || m_c !== 64'd42) bad++;
    end
    @(posedge clk); #1 force_ov = 1'b0; m_ready = 1'b1;
    @(posedge clk);
    chk("stray_hold", 64'(bad), 64'd0);
    repeat (3) @(negedge clk);
    chk("stray_no_extra", 64'(m_valid), 64'd0);

    // Reset in the middle of WAIT; the late multiplier o_valid must be ignored.
    push_one(32'd100, 32'd200);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_m_c", m_c, 64'd0);
    chk("midrst_i_valid", 64'(mult_i_valid), 64'd0);
    chk("midrst_i_a", 64'(mult_i_a), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("postrst_s_ready", 64'(s_ready), 64'd1);
    chk("postrst_busy", 64'(busy), 64'd0);
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (m_valid || busy) bad++;
    end
    chk("late_o_valid_ignored", 64'(bad), 64'd0);

    // Randomized traffic with random backpressure against the scoreboard.
    sent = 0;
    acc = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        s_valid = 1'b0;
      end
      if (!s_valid && sent < N_RAND && $urandom_range(0, 2) != 0) begin
        s_valid = 1'b1;
        s_a = rnd_op();
        s_b = rnd_op();
      end
      m_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = s_valid && s_ready;
      if (sent == N_RAND && !s_valid) break;
    end
    s_valid = 1'b0;
    chk("rand_all_sent", 64'(sent), 64'(N_RAND));
    @(posedge clk); #1 m_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    chk("rand_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
